rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 Parameter RF_DEPTH, default 32, number of architectural registers tracked.
REQ-002 Parameter CNT_W, default 2, width of each per-register pending-write counter (max 2^CNT_W-1 outstanding writes per register).
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 issue_valid  in  1  decoder presents an instruction for register read.
REQ-006 issue_ready  out  1  instruction may proceed to register read this cycle.
REQ-007 issue_rs1 / issue_rs2  in  5 each  source register indices.
REQ-008 issue_rs1_en / issue_rs2_en  in  1 each  source actually read.
REQ-009 issue_rd  in  5  destination register index; issue_rd_en  in  1  instruction writes rd.
REQ-010 wb_valid  in  1  write back to register file accepted this cycle; wb_rd  in  5  its destination.
REQ-011 fwd_rs1 / fwd_rs2  out  1 each  operand taken from same-cycle write back, not the array.
REQ-012 invalidate  in  1  pipeline flush, all in-flight writes discarded.
REQ-013 busy_mask  out  RF_DEPTH  bit r set when cnt[r] != 0.
REQ-014 sb_error  out  1  sticky, write back seen for register with zero pending count.

Function
REQ-015 fire = issue_valid && issue_ready; issue_ready SHALL be purely combinational from current inputs and state (zero-cycle latency).
REQ-016 Register 0 SHALL never be tracked: cnt[0] stays 0, rs=0 never hazards, rd=0 never increments.
REQ-017 Source hazard hz1 SHALL be issue_rs1_en && rs1!=0 && cnt[rs1]!=0, except when cnt[rs1]==1 && wb_valid && wb_rd==rs1; same rule for rs2.
REQ-018 fwd_rs1 SHALL be 1 exactly when the exception in REQ-017 applies for rs1; same for fwd_rs2; both 0 when the respective _en is 0.
REQ-019 WAW saturation stall SHALL apply when issue_rd_en && rd!=0 && cnt[rd] is all-ones, unless wb_valid && wb_rd==rd in the same cycle.
REQ-020 issue_ready SHALL be !invalidate && !hz1 && !hz2 && !saturation stall.
REQ-021 Per register r != 0: inc = fire && issue_rd_en && issue_rd==r; dec = wb_valid && wb_rd==r && cnt[r]!=0; next cnt = cnt + inc - dec (simultaneous inc and dec: unchanged).
REQ-022 Counter arithmetic SHALL never wrap: overflow prevented by REQ-019, underflow prevented by the cnt!=0 guard.
REQ-023 wb_valid with wb_rd!=0 and cnt[wb_rd]==0 (without invalidate) SHALL set sb_error on the next edge; counter unchanged.
REQ-024 invalidate SHALL clear all counters on the next edge, override any same-cycle inc/dec, and not set sb_error.
REQ-025 busy_mask SHALL reflect registered counter state (no same-cycle write back bypass).
REQ-026 Independent of issue_valid: issue_ready SHALL be evaluated even when issue_valid is 0; no state changes without fire, wb_valid or invalidate.

Reset
REQ-027 While rst=0: all counters 0, busy_mask=0, sb_error=0, issue_ready follows REQ-020 with zero state.
REQ-028 Reset asserted mid-operation SHALL clear state immediately, without waiting for clk; pending write backs after release against zero counters SHALL set sb_error.
REQ-029 sb_error SHALL clear only by reset.

Verification
REQ-030 Issue rd=5, next cycle issue rs1=5 with no write back -> issue_ready=0, busy_mask[5]=1; wb_valid,wb_rd=5 -> issue_ready=1, fwd_rs1=1; next cycle busy_mask[5]=0.
REQ-031 Issue rd=7 three times (CNT_W=2) -> cnt[7]=3; fourth issue rd=7 -> issue_ready=0; same cycle wb_rd=7 -> issue_ready=1, cnt[7] stays 3.
REQ-032 cnt[9]=2, wb_rd=9 and issue rs1=9 -> issue_ready=0, fwd_rs1=0; cnt[9]=1 next cycle.
REQ-033 Issue rd=0 and rs1=0 repeatedly -> issue_ready=1, busy_mask=0 throughout.
REQ-034 Several busy registers, invalidate=1 with simultaneous fire attempt and wb -> issue_ready=0; next cycle busy_mask=0, sb_error=0.
REQ-035 wb_valid, wb_rd=12 with cnt[12]=0 -> sb_error=1 next cycle, remains 1 until rst=0 asynchronously clears it.

Source files
------------

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters that stall reads
// on RAW hazards and flag same-cycle write-back forwarding.
module rf_scoreboard #(
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [4:0]          issue_rs1_i,
    input  logic [4:0]          issue_rs2_i,
    input  logic                issue_rs1_en_i,
    input  logic                issue_rs2_en_i,
    input  logic [4:0]          issue_rd_i,
    input  logic                issue_rd_en_i,
    input  logic                wb_valid_i,
    input  logic [4:0]          wb_rd_i,
    output logic                fwd_rs1_o,
    output logic                fwd_rs2_o,
    input  logic                invalidate_i,
    output logic [RF_DEPTH-1:0] busy_mask_o,
    output logic                sb_error_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [RF_DEPTH];
    logic [CNT_W-1:0] cnt_d [RF_DEPTH];
    logic             sb_error_q, sb_error_d;

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
    logic             wb_tracked;
    logic             hit1, hit2, byp1, byp2, hz1, hz2, sat_stall, wb_hits_rd;
    logic             fire, inc, dec;

    // Register 0 is never looked up: the loops start at 1 so its view reads as zero.
    always_comb begin
        cnt_rs1    = '0;
        cnt_rs2    = '0;
        cnt_rd     = '0;
        cnt_wb     = '0;
        wb_tracked = 1'b0;
        for (int unsigned r = 1; r < RF_DEPTH; r++) begin
            if (issue_rs1_i == 5'(r)) cnt_rs1 = cnt_q[r];
            if (issue_rs2_i == 5'(r)) cnt_rs2 = cnt_q[r];
            if (issue_rd_i == 5'(r))  cnt_rd  = cnt_q[r];
            if (wb_rd_i == 5'(r)) begin
                cnt_wb     = cnt_q[r];
                wb_tracked = 1'b1;
            end
        end
    end

    always_comb begin
        hit1       = issue_rs1_en_i && (cnt_rs1 != '0);
        hit2       = issue_rs2_en_i && (cnt_rs2 != '0);
        // The last outstanding write landing this cycle can be forwarded instead of stalling.
        byp1       = (cnt_rs1 == CntOne) && wb_valid_i && (wb_rd_i == issue_rs1_i);
        byp2       = (cnt_rs2 == CntOne) && wb_valid_i && (wb_rd_i == issue_rs2_i);
        hz1        = hit1 && !byp1;
        hz2        = hit2 && !byp2;
        fwd_rs1_o  = hit1 && byp1;
        fwd_rs2_o  = hit2 && byp2;
        wb_hits_rd = wb_valid_i && (wb_rd_i == issue_rd_i);
        sat_stall  = issue_rd_en_i && (cnt_rd == CntMax) && !wb_hits_rd;
        issue_ready_o = !invalidate_i && !hz1 && !hz2 && !sat_stall;
        fire       = issue_valid_i && issue_ready_o;
    end

    always_comb begin
        inc = 1'b0;
        dec = 1'b0;
        for (int unsigned r = 0; r < RF_DEPTH; r++) cnt_d[r] = cnt_q[r];
        for (int unsigned r = 1; r < RF_DEPTH; r++) begin
            inc = fire && issue_rd_en_i && (issue_rd_i == 5'(r));
            dec = wb_valid_i && (wb_rd_i == 5'(r)) && (cnt_q[r] != '0);
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CntOne;
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CntOne;
            end
        end
        if (invalidate_i) begin
            for (int unsigned r = 0; r < RF_DEPTH; r++) cnt_d[r] = '0;
        end
        sb_error_d = sb_error_q ||
                     (wb_valid_i && wb_tracked && (cnt_wb == '0) && !invalidate_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < RF_DEPTH; r++) cnt_q[r] <= '0;
            sb_error_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < RF_DEPTH; r++) cnt_q[r] <= cnt_d[r];
            sb_error_q <= sb_error_d;
        end
    end

    always_comb begin
        busy_mask_o = '0;
        for (int unsigned r = 0; r < RF_DEPTH; r++) busy_mask_o[r] = (cnt_q[r] != '0);
    end

    assign sb_error_o = sb_error_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: hazards, forwarding, saturation, flush, error flag.
module tb_rf_scoreboard;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        issue_valid_i, issue_ready_o;
    logic [4:0]  issue_rs1_i, issue_rs2_i, issue_rd_i, wb_rd_i;
    logic        issue_rs1_en_i, issue_rs2_en_i, issue_rd_en_i;
    logic        wb_valid_i, fwd_rs1_o, fwd_rs2_o, invalidate_i, sb_error_o;
    logic [31:0] busy_mask_o;

    int n_checks = 0;
    int n_pass   = 0;

    rf_scoreboard #(.RF_DEPTH(32), .CNT_W(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_rs1_i    (issue_rs1_i),
        .issue_rs2_i    (issue_rs2_i),
        .issue_rs1_en_i (issue_rs1_en_i),
        .issue_rs2_en_i (issue_rs2_en_i),
        .issue_rd_i     (issue_rd_i),
        .issue_rd_en_i  (issue_rd_en_i),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .fwd_rs1_o      (fwd_rs1_o),
        .fwd_rs2_o      (fwd_rs2_o),
        .invalidate_i   (invalidate_i),
        .busy_mask_o    (busy_mask_o),
        .sb_error_o     (sb_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        issue_valid_i  = 1'b0;
        issue_rs1_i    = '0;
        issue_rs2_i    = '0;
        issue_rd_i     = '0;
        issue_rs1_en_i = 1'b0;
        issue_rs2_en_i = 1'b0;
        issue_rd_en_i  = 1'b0;
        wb_valid_i     = 1'b0;
        wb_rd_i        = '0;
        invalidate_i   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue_rd(input logic [4:0] rd);
        idle();
        issue_valid_i = 1'b1;
        issue_rd_en_i = 1'b1;
        issue_rd_i    = rd;
        tick();
        idle();
    endtask

    task automatic writeback(input logic [4:0] rd);
        idle();
        wb_valid_i = 1'b1;
        wb_rd_i    = rd;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        issue_valid_i  = 1'b1;
        issue_rs1_en_i = 1'b1;
        issue_rs1_i    = 5'd3;
        #2;
        n_checks++;
        if (busy_mask_o !== 32'h0) $display("FAIL reset_busy got=%h exp=0", busy_mask_o);
        else n_pass++;
        n_checks++;
        if (sb_error_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", sb_error_o);
        else n_pass++;
        n_checks++;
        if (issue_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", issue_ready_o);
        else n_pass++;
        #10;
        rst_ni = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_raw_fwd();
        issue_rd(5'd5);
        issue_valid_i  = 1'b1;
        issue_rs1_en_i = 1'b1;
        issue_rs1_i    = 5'd5;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b0) $display("FAIL raw_stall got=%b exp=0", issue_ready_o);
        else n_pass++;
        n_checks++;
        if (busy_mask_o !== 32'h20) $display("FAIL raw_busy got=%h exp=20", busy_mask_o);
        else n_pass++;
        issue_rs1_en_i = 1'b0;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b1) $display("FAIL raw_en_gate got=%b exp=1", issue_ready_o);
        else n_pass++;
        issue_rs1_en_i = 1'b1;
        wb_valid_i     = 1'b1;
        wb_rd_i        = 5'd5;
        #1;
        n_checks++;
        if ({issue_ready_o, fwd_rs1_o, fwd_rs2_o} !== 3'b110)
            $display("FAIL raw_fwd got rdy/f1/f2=%b exp=110", {issue_ready_o, fwd_rs1_o, fwd_rs2_o});
        else n_pass++;
        n_checks++;
        if (busy_mask_o !== 32'h20) $display("FAIL raw_busy_nobypass got=%h exp=20", busy_mask_o);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_mask_o !== 32'h0) $display("FAIL raw_drain got=%h exp=0", busy_mask_o);
        else n_pass++;
    endtask

    task automatic test_waw_sat();
        for (int i = 0; i < 3; i++) issue_rd(5'd7);
        issue_valid_i = 1'b1;
        issue_rd_en_i = 1'b1;
        issue_rd_i    = 5'd7;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b0) $display("FAIL sat_stall got=%b exp=0", issue_ready_o);
        else n_pass++;
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd7;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b1) $display("FAIL sat_wb_release got=%b exp=1", issue_ready_o);
        else n_pass++;
        tick();
        wb_valid_i = 1'b0;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b0) $display("FAIL sat_still_full got=%b exp=0", issue_ready_o);
        else n_pass++;
        writeback(5'd7);
        writeback(5'd7);
        #1;
        n_checks++;
        if (busy_mask_o !== 32'h80) $display("FAIL sat_one_left got=%h exp=80", busy_mask_o);
        else n_pass++;
        writeback(5'd7);
        #1;
        n_checks++;
        if (busy_mask_o !== 32'h0) $display("FAIL sat_drain got=%h exp=0", busy_mask_o);
        else n_pass++;
    endtask

    task automatic test_multi_pending();
        issue_rd(5'd9);
        issue_rd(5'd9);
        issue_valid_i  = 1'b1;
        issue_rs1_en_i = 1'b1;
        issue_rs1_i    = 5'd9;
        wb_valid_i     = 1'b1;
        wb_rd_i        = 5'd9;
        #1;
        n_checks++;
        if ({issue_ready_o, fwd_rs1_o} !== 2'b00)
            $display("FAIL cnt2_stall got rdy/f1=%b exp=00", {issue_ready_o, fwd_rs1_o});
        else n_pass++;
        tick();
        wb_valid_i = 1'b0;
        #1;
        n_checks++;
        if ({issue_ready_o, busy_mask_o[9]} !== 2'b01)
            $display("FAIL cnt1_stall got rdy/busy9=%b exp=01", {issue_ready_o, busy_mask_o[9]});
        else n_pass++;
        wb_valid_i = 1'b1;
        #1;
        n_checks++;
        if ({issue_ready_o, fwd_rs1_o} !== 2'b11)
            $display("FAIL cnt1_fwd got rdy/f1=%b exp=11", {issue_ready_o, fwd_rs1_o});
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_mask_o !== 32'h0) $display("FAIL cnt_drain got=%h exp=0", busy_mask_o);
        else n_pass++;
    endtask

    task automatic test_reg0();
        for (int i = 0; i < 4; i++) begin
            idle();
            issue_valid_i  = 1'b1;
            issue_rd_en_i  = 1'b1;
            issue_rs1_en_i = 1'b1;
            issue_rs2_en_i = 1'b1;
            #1;
            n_checks++;
            if ({issue_ready_o, fwd_rs1_o, fwd_rs2_o} !== 3'b100 || busy_mask_o !== 32'h0)
                $display("FAIL reg0_%0d got rdy/f1/f2=%b busy=%h exp=100/0", i,
                         {issue_ready_o, fwd_rs1_o, fwd_rs2_o}, busy_mask_o);
            else n_pass++;
            tick();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        issue_rd(5'd2);
        issue_valid_i  = 1'b1;
        issue_rs2_en_i = 1'b1;
        issue_rs2_i    = 5'd2;
        issue_rd_en_i  = 1'b1;
        issue_rd_i     = 5'd2;
        wb_valid_i     = 1'b1;
        wb_rd_i        = 5'd2;
        #1;
        n_checks++;
        if ({issue_ready_o, fwd_rs1_o, fwd_rs2_o} !== 3'b101)
            $display("FAIL b2b_fwd2 got rdy/f1/f2=%b exp=101", {issue_ready_o, fwd_rs1_o, fwd_rs2_o});
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_mask_o !== 32'h4) $display("FAIL b2b_incdec got=%h exp=4", busy_mask_o);
        else n_pass++;
        writeback(5'd2);
        #1;
        n_checks++;
        if (busy_mask_o !== 32'h0 || sb_error_o !== 1'b0)
            $display("FAIL b2b_drain got busy=%h err=%b exp=0/0", busy_mask_o, sb_error_o);
        else n_pass++;
    endtask

    task automatic test_invalidate();
        issue_rd(5'd3);
        issue_rd(5'd4);
        issue_rd(5'd6);
        #1;
        n_checks++;
        if (busy_mask_o !== 32'h58) $display("FAIL inv_pre got=%h exp=58", busy_mask_o);
        else n_pass++;
        issue_valid_i = 1'b1;
        issue_rd_en_i = 1'b1;
        issue_rd_i    = 5'd10;
        wb_valid_i    = 1'b1;
        wb_rd_i       = 5'd3;
        invalidate_i  = 1'b1;
        #1;
        n_checks++;
        if (issue_ready_o !== 1'b0) $display("FAIL inv_ready got=%b exp=0", issue_ready_o);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_mask_o !== 32'h0 || sb_error_o !== 1'b0)
            $display("FAIL inv_clear got busy=%h err=%b exp=0/0", busy_mask_o, sb_error_o);
        else n_pass++;
    endtask

    task automatic test_sb_error();
        writeback(5'd12);
        #1;
        n_checks++;
        if ({sb_error_o, busy_mask_o[12]} !== 2'b10)
            $display("FAIL err_set got err/busy12=%b exp=10", {sb_error_o, busy_mask_o[12]});
        else n_pass++;
        issue_rd(5'd8);
        tick();
        n_checks++;
        if ({sb_error_o, busy_mask_o[8]} !== 2'b11)
            $display("FAIL err_sticky got err/busy8=%b exp=11", {sb_error_o, busy_mask_o[8]});
        else n_pass++;
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (sb_error_o !== 1'b0 || busy_mask_o !== 32'h0)
            $display("FAIL async_rst got err=%b busy=%h exp=0/0", sb_error_o, busy_mask_o);
        else n_pass++;
        #2;
        rst_ni = 1'b1;
        writeback(5'd8);
        #1;
        n_checks++;
        if (sb_error_o !== 1'b1) $display("FAIL err_after_rst got=%b exp=1", sb_error_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_raw_fwd();
        test_waw_sat();
        test_multi_pending();
        test_reg0();
        test_back_to_back();
        test_invalidate();
        test_sb_error();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
